// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Fetch/decode/execute/writeback sequencer for the 8-bit ALU.
//               Fetches 14-bit instructions over a req/valid handshake, drives
//               the ALU opcode and operands, writes results into W or a
//               16 x 8 file register and maintains the Z/C flags and the PC.
//               Optional build macro ALU_SEQ_SKIP_EN: a zero result of
//               inc/dec with instr[5] set makes writeback skip one
//               instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int RF_DEPTH = 16,
    parameter int PC_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    input  logic [13:0]     instr_data,
    output logic [3:0]      alu_inst,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_bit,
    input  logic [7:0]      alu_ans,
    input  logic            alu_carry,
    output logic [7:0]      w_reg,
    output logic [1:0]      status,
    output logic            halted
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    localparam logic [3:0] c_op_nop  = 4'd8;
    localparam logic [3:0] c_op_halt = 4'd15;

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);
    localparam logic [PC_W-1:0] c_pc_two = PC_W'(2);

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_w;
    logic            r_z;
    logic            r_c;
    logic [7:0]      r_file [RF_DEPTH];
    logic [3:0]      r_op;
    logic            r_dest;
    logic [3:0]      r_addr;
    logic            r_req;
    logic            r_halted;
    logic [3:0]      r_alu_inst;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [2:0]      r_alu_bit;

    logic            w_upd_c;
    logic            w_upd_z;
    logic            w_res_zero;
    logic [PC_W-1:0] w_pc_next;
    logic            w_unused_bits;

`ifdef ALU_SEQ_SKIP_EN
    logic            r_skip;
    // Bit 4 is reserved and never decoded.
    assign w_unused_bits = instr_data[4];
`else
    // Without the skip feature neither the skip flag nor the reserved bit is decoded.
    assign w_unused_bits = ^instr_data[5:4];
`endif

    assign w_res_zero = (alu_ans == 8'h00);

    // Decide which flags the current opcode is allowed to update.
    always_comb begin
        w_upd_c = 1'b0;
        w_upd_z = 1'b0;
        case (r_op)
            4'd2, 4'd3, 4'd5, 4'd6: begin
                w_upd_c = 1'b1;
                w_upd_z = 1'b1;
            end
            4'd0, 4'd1, 4'd4, 4'd7, 4'd9, 4'd10, 4'd12: w_upd_z = 1'b1;
            default: ;
        endcase
    end

    // Next program counter at writeback: normally +1, +2 when a skip fires.
    always_comb begin
        w_pc_next = r_pc + c_pc_one;
`ifdef ALU_SEQ_SKIP_EN
        if (r_skip && ((r_op == 4'd5) || (r_op == 4'd6)) && w_res_zero) begin
            w_pc_next = r_pc + c_pc_two;
        end
`endif
    end

    // Sequencer state machine with all architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_pc       <= '0;
            r_w        <= 8'h00;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_op       <= c_op_nop;
            r_dest     <= 1'b0;
            r_addr     <= 4'h0;
            r_req      <= 1'b0;
            r_halted   <= 1'b0;
            r_alu_inst <= c_op_nop;
            r_alu_a    <= 8'h00;
            r_alu_b    <= 8'h00;
            r_alu_bit  <= 3'd0;
`ifdef ALU_SEQ_SKIP_EN
            r_skip     <= 1'b0;
`endif
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_file[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_req   <= 1'b1;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    // The bit index goes out with the latch so it is stable from DECODE on.
                    if (instr_valid) begin
                        r_op      <= instr_data[13:10];
                        r_dest    <= instr_data[9];
                        r_alu_bit <= instr_data[8:6];
                        r_addr    <= instr_data[3:0];
`ifdef ALU_SEQ_SKIP_EN
                        r_skip    <= instr_data[5];
`endif
                        r_req     <= 1'b0;
                        r_state   <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    // Operands are captured here so they are presented through EXEC and WB.
                    if (r_op == c_op_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= c_st_halt;
                    end else begin
                        r_alu_inst <= r_op;
                        r_alu_a    <= r_w;
                        r_alu_b    <= r_file[r_addr];
                        r_state    <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    r_state <= c_st_wb;
                end
                c_st_wb: begin
                    if (r_op != c_op_nop) begin
                        if (r_dest) begin
                            r_file[r_addr] <= alu_ans;
                        end else begin
                            r_w <= alu_ans;
                        end
                    end
                    if (w_upd_c) begin
                        r_c <= alu_carry;
                    end
                    if (w_upd_z) begin
                        r_z <= w_res_zero;
                    end
                    r_pc       <= w_pc_next;
                    r_alu_inst <= c_op_nop;
                    r_req      <= 1'b1;
                    r_state    <= c_st_fetch;
                end
                c_st_halt: begin
                    // The halt instruction itself is stepped over on restart.
                    if (start) begin
                        r_pc     <= r_pc + c_pc_one;
                        r_halted <= 1'b0;
                        r_req    <= 1'b1;
                        r_state  <= c_st_fetch;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign instr_req = r_req;
    assign pc        = r_pc;
    assign alu_inst  = r_alu_inst;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_bit   = r_alu_bit;
    assign w_reg     = r_w;
    assign status    = {r_z, r_c};
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. A behavioural ALU and
//               program memory surround the DUT; an instruction-level model
//               predicts the architectural state seen at every fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

`ifdef ALU_SEQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [13:0] HALT_W = 14'h3C00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        instr_req;
    logic [7:0]  pc;
    logic        instr_valid;
    logic [13:0] instr_data;
    logic [3:0]  alu_inst;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_bit;
    logic [7:0]  alu_ans;
    logic        alu_carry;
    logic [7:0]  w_reg;
    logic [1:0]  status;
    logic        halted;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [13:0] prog [256];
    logic        mem_rdy = 1'b1;
    logic        waits   = 1'b0;
    logic        noisy   = 1'b1;
    logic [13:0] junk    = 14'h0;

    logic [17:0] snaps[$];
    logic [17:0] exp_q[$];
    int          fetch_cyc[$];

    logic [7:0]  m_w;
    logic [7:0]  m_file [16];
    logic        m_z;
    logic        m_c;
    logic [7:0]  m_pc;

    always #5 clk = ~clk;

    alu_sequencer #(.RF_DEPTH(16), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_req(instr_req), .pc(pc),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_bit(alu_bit),
        .alu_ans(alu_ans), .alu_carry(alu_carry),
        .w_reg(w_reg), .status(status), .halted(halted)
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] bn);
        logic [7:0] m;
        m = 8'd1 << bn;
        case (op)
            4'd0:  return {1'b0, b};
            4'd1:  return {1'b0, a};
            4'd2:  return {1'b0, a} + {1'b0, b};
            4'd3:  return {1'b0, b} - {1'b0, a};
            4'd4:  return {1'b0, a & b};
            4'd5:  return {1'b0, b} + 9'd1;
            4'd6:  return {1'b0, b} - 9'd1;
            4'd7:  return {1'b0, a ^ b};
            4'd9:  return 9'd0;
            4'd10: return {1'b0, a | b};
            4'd11: return {1'b0, b[3:0], b[7:4]};
            4'd12: return {1'b0, ~b};
            4'd13: return {1'b0, b | m};
            4'd14: return {1'b0, b & ~m};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_ans} = alu_fn(alu_inst, alu_a, alu_b, alu_bit);
    assign instr_valid = instr_req ? mem_rdy : noisy;
    assign instr_data  = instr_req ? prog[pc] : junk;

    // Memory wait states and junk data change just after the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #2;
        mem_rdy = waits ? ($urandom_range(0, 2) != 0) : 1'b1;
        junk    = 14'($urandom);
    end

    // Record architectural state at every accepted fetch.
    always @(negedge clk) begin
        if (!reset && instr_req && instr_valid) begin
            snaps.push_back({pc, w_reg, status});
            fetch_cyc.push_back(cyc);
        end
    end

    function automatic logic [13:0] enc(input int op, input int d, input int bn, input int sk, input int addr);
        return {op[3:0], d[0], bn[2:0], sk[0], 1'b0, addr[3:0]};
    endfunction

    function automatic logic [17:0] snap_at(input int i);
        if (i < snaps.size()) return snaps[i];
        return 'x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w = 8'h00; m_z = 1'b0; m_c = 1'b0; m_pc = 8'h00;
        for (int i = 0; i < 16; i++) m_file[i] = 8'h00;
    endtask

    // Instruction-level reference: executes from m_pc until a halt is fetched.
    task automatic model_run();
        logic [13:0] ins;
        logic [3:0]  op;
        logic [8:0]  r;
        int          step;
        for (int n = 0; n < 2000; n++) begin
            ins = prog[m_pc];
            exp_q.push_back({m_pc, m_w, m_z, m_c});
            op = ins[13:10];
            if (op == 4'd15) break;
            r = alu_fn(op, m_w, m_file[ins[3:0]], ins[8:6]);
            if (op != 4'd8) begin
                if (ins[9]) m_file[ins[3:0]] = r[7:0];
                else        m_w = r[7:0];
            end
            if (op inside {4'd2, 4'd3, 4'd5, 4'd6}) m_c = r[8];
            if (op inside {[4'd0:4'd7], 4'd9, 4'd10, 4'd12}) m_z = (r[7:0] == 8'h00);
            step = (SKIP && ins[5] && (op inside {4'd5, 4'd6}) && (r[7:0] == 8'h00)) ? 2 : 1;
            m_pc = m_pc + 8'(step);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = HALT_W;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; start = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        snaps.delete(); exp_q.delete(); fetch_cyc.delete();
        model_reset();
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin @(negedge clk); n++; end
        check({tag, " halt reached"}, 32'(halted), 32'd1);
    endtask

    task automatic cmp_run(input string tag);
        check({tag, " fetch count"}, snaps.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < snaps.size(); i++)
            check($sformatf("%s fetch%0d {pc,w,zc}", tag, i), 32'(snaps[i]), 32'(exp_q[i]));
        check({tag, " final pc"}, 32'(pc), 32'(m_pc));
        check({tag, " final w"}, 32'(w_reg), 32'(m_w));
        check({tag, " final zc"}, 32'(status), 32'({m_z, m_c}));
    endtask

    initial begin
        logic [17:0] s;
        int n;

        // Reset state
        clear_prog();
        do_reset();
        check("rst pc", 32'(pc), 0);
        check("rst w", 32'(w_reg), 0);
        check("rst status", 32'(status), 0);
        check("rst req", 32'(instr_req), 0);
        check("rst alu_inst", 32'(alu_inst), 8);
        check("rst alu_a", 32'(alu_a), 0);
        check("rst alu_b", 32'(alu_b), 0);
        check("rst alu_bit", 32'(alu_bit), 0);
        check("rst halted", 32'(halted), 0);
        repeat (3) @(negedge clk);
        check("idle ignores valid", 32'(instr_req), 0);

        // Clear then complement W, zero-wait timing
        prog[0] = enc(9, 0, 0, 0, 0);
        prog[1] = enc(12, 0, 0, 0, 0);
        model_run();
        pulse_start();
        wait_halt("t1", 100);
        cmp_run("t1");
        s = snap_at(1); check("t1 clr w", 32'(s[9:2]), 32'h00); check("t1 clr zc", 32'(s[1:0]), 32'h2);
        s = snap_at(2); check("t1 com w", 32'(s[9:2]), 32'hFF); check("t1 com zc", 32'(s[1:0]), 32'h0);
        check("t1 spacing a", fetch_cyc.size() >= 3 ? fetch_cyc[1] - fetch_cyc[0] : -1, 4);
        check("t1 spacing b", fetch_cyc.size() >= 3 ? fetch_cyc[2] - fetch_cyc[1] : -1, 4);

        // Add into file with carry out
        do_reset(); clear_prog();
        for (int b = 4; b < 8; b++) prog[b-4] = enc(13, 1, b, 0, 0);
        prog[4] = enc(0, 0, 0, 0, 0);
        prog[5] = enc(13, 1, 5, 0, 2);
        prog[6] = enc(2, 1, 0, 0, 2);
        prog[7] = enc(0, 0, 0, 0, 2);
        model_run(); pulse_start(); wait_halt("t2", 200); cmp_run("t2");
        s = snap_at(7); check("t2 add w kept", 32'(s[9:2]), 32'hF0); check("t2 add zc", 32'(s[1:0]), 32'h1);
        s = snap_at(8); check("t2 file2", 32'(s[9:2]), 32'h10);

        // Bit set / clear leave flags alone
        do_reset(); clear_prog();
        prog[0] = enc(9, 0, 0, 0, 0);
        prog[1] = enc(13, 1, 7, 0, 5);
        prog[2] = enc(11, 0, 0, 0, 5);
        prog[3] = enc(14, 1, 7, 0, 5);
        prog[4] = enc(11, 0, 0, 0, 5);
        model_run(); pulse_start(); wait_halt("t3", 200); cmp_run("t3");
        s = snap_at(3); check("t3 bset", 32'(s[9:2]), 32'h08); check("t3 bset zc", 32'(s[1:0]), 32'h2);
        s = snap_at(5); check("t3 bclr", 32'(s[9:2]), 32'h00); check("t3 bclr zc", 32'(s[1:0]), 32'h2);

        // Decrement with skip flag at pc 0x10
        do_reset(); clear_prog();
        prog[0] = enc(5, 1, 0, 0, 1);
        for (int i = 1; i < 16; i++) prog[i] = enc(8, 0, 0, 0, 0);
        prog[16] = enc(6, 1, 0, 1, 1);
        model_run(); pulse_start(); wait_halt("t4", 300); cmp_run("t4");
        s = snap_at(17); check("t4 pc after dec", 32'(s[17:10]), SKIP ? 32'h12 : 32'h11);
        check("t4 dec zc", 32'(s[1:0]), 32'h2);

        // PC wrap with skip at 0xFF, restart from HALT
        do_reset(); clear_prog();
        prog[0] = enc(5, 1, 0, 0, 1);
        for (int i = 2; i < 255; i++) prog[i] = enc(8, 0, 0, 0, 0);
        prog[255] = enc(6, 1, 0, 1, 1);
        model_run(); pulse_start(); wait_halt("t5a", 100);
        check("t5 halt pc", 32'(pc), 1);
        m_pc = m_pc + 8'd1; model_run();
        pulse_start(); wait_halt("t5b", 2000); cmp_run("t5");
        s = snap_at(256); check("t5 wrap pc", 32'(s[17:10]), SKIP ? 32'h01 : 32'h00);

        // Halt at 0x07 and restart
        do_reset(); clear_prog();
        for (int i = 0; i < 7; i++) prog[i] = enc(8, 0, 0, 0, 0);
        prog[8] = enc(9, 0, 0, 0, 0);
        model_run(); pulse_start(); wait_halt("t6a", 100);
        repeat (3) @(negedge clk);
        check("t6 halted", 32'(halted), 1);
        check("t6 pc held", 32'(pc), 7);
        check("t6 no req", 32'(instr_req), 0);
        m_pc = m_pc + 8'd1; model_run();
        pulse_start(); wait_halt("t6b", 100); cmp_run("t6");
        s = snap_at(8); check("t6 restart pc", 32'(s[17:10]), 32'h08);

        // Reset during EXEC of an add to W
        do_reset(); clear_prog();
        prog[0] = enc(2, 0, 0, 0, 0);
        pulse_start();
        n = 0;
        while (!(instr_req && instr_valid) && n < 20) begin @(negedge clk); n++; end
        check("t7 fetch seen", 32'(n < 20), 1);
        @(negedge clk); @(negedge clk);
        check("t7 exec alu_inst", 32'(alu_inst), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7 w", 32'(w_reg), 0);
        check("t7 status", 32'(status), 0);
        check("t7 alu_inst", 32'(alu_inst), 8);
        @(negedge clk);
        check("t7 idle req", 32'(instr_req), 0);

        // Randomized programs with wait states and bus noise
        for (int r = 0; r < 4; r++) begin
            do_reset(); clear_prog();
            waits = r[0];
            for (int i = 0; i < 40; i++) prog[i] = {4'($urandom_range(0, 14)), 10'($urandom)};
            for (int j = 0; j < 16; j++) prog[40+j] = enc(0, 0, 0, 0, j);
            model_run(); pulse_start();
            wait_halt($sformatf("rnd%0d", r), 1500);
            cmp_run($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
